mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage load/store unit of the five-stage RISC-V pipeline. It consumes the Mem-stage control (MemWrite_M, MemRead_M, and the memory-type funct3 carried down the controller pipeline), together with the ALU address and store data. It runs a request/acknowledge transaction to data memory, with byte-lane strobes and load sign/zero extension. It stalls the pipeline until the access completes, and flags misaligned, illegal and timed-out accesses.

## Interface
- TIMEOUT_CYCLES, 16: cycles to wait in REQ for Dmem_Ack before aborting; minimum 1.
- Clk  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- MemRead_M  in  1  load in Mem stage
- MemWrite_M  in  1  store in Mem stage; MemRead_M and MemWrite_M are never both 1
- Funct3_M  in  3  memory type: 000 B, 001 H, 010 W, 100 BU, 101 HU
- Addr_M  in  32  byte address from ALU
- WriteData_M  in  32  store data (low bits significant)
- Dmem_Req  out  1  request valid, held until acknowledged
- Dmem_We  out  1  1 = write
- Dmem_Addr  out  32  word address ({Addr_M[31:2],2'b00})
- Dmem_WStrb  out  4  byte-lane write enables
- Dmem_WData  out  32  lane-replicated store data
- Dmem_Ack  in  1  memory completes the request this cycle
- Dmem_RData  in  32  read word, valid with Dmem_Ack
- ReadData_M  out  32  extended load result
- Stall_M  out  1  freeze IF/ID/EX/Mem registers
- Misaligned_M  out  1  one-cycle pulse: misaligned access, not issued
- Access_Fault_M  out  1  one-cycle pulse: illegal funct3 or bus timeout

## Operation
- States: IDLE, REQ, DONE.
- IDLE, no access: Stall_M=0, outputs quiescent.
- IDLE, access present, legal and aligned:
  - Stall_M=1 combinationally.
  - Register Dmem_Addr/We/WStrb/WData.
  - Move to REQ.
- IDLE, misaligned access (H/HU with Addr[0]=1; W with Addr[1:0]≠0):
  - Misaligned_M=1 for that cycle; no request; Stall_M=0; stay IDLE.
- IDLE, illegal funct3 (011, 110, 111; any store funct3 other than 000/001/010): Access_Fault_M=1, no request, Stall_M=0.
- REQ:
  - Dmem_Req=1, Stall_M=1; timeout counter increments each cycle.
  - Ack sampled at the edge: capture extended Dmem_RData into ReadData_M (loads), go to DONE.
  - Counter reaches TIMEOUT_CYCLES without Ack: drop Req, go to DONE with Access_Fault_M pulsed in DONE and ReadData_M=0.
- DONE: Stall_M=0, ReadData_M valid; the pipeline advances at this edge; return to IDLE.
- Store lanes:
  - SB: WStrb=1<<Addr[1:0], WData={4{byte}}.
  - SH: WStrb=Addr[1]?1100:0011, WData={2{half}}.
  - SW: WStrb=1111.
  - Loads: WStrb=0000.
- Load extract:
  - Byte = RData[8*Addr[1:0] +: 8]; half = RData[16*Addr[1] +: 16].
  - B/H sign-extend; BU/HU zero-extend; W passes through.

## Timing
- Reset values: state IDLE; Dmem_Req=0, Dmem_We=0, Dmem_Addr=0, Dmem_WStrb=0, Dmem_WData=0, ReadData_M=0; counter=0. Stall_M, Misaligned_M and Access_Fault_M are 0 in IDLE with no access.
- Minimum access: access seen at cycle t (stall); Req high at t+1; Ack at t+1; DONE at t+2. Three cycles total, two stalled.
- Each Ack cycle beyond the first adds one stalled cycle.
- Inputs are held stable by the pipeline while Stall_M=1; the block does not re-sample them after leaving IDLE.
- Ack while in IDLE or DONE (stray or late) is ignored.
- Reset in REQ: Req deasserts at that edge, state IDLE. An Ack arriving afterwards is ignored.
- Reset takes priority over Ack and timeout in the same cycle.
- Timeout and Ack on the same edge: Ack wins, no fault.

## Structure
- Package mem_access_pkg holds:
  - funct3 memory-type constants (MT_B, MT_H, MT_W, MT_BU, MT_HU);
  - the state enum;
  - the TIMEOUT_CYCLES default.
- Sub-module load_extend: combinational; RData, Addr[1:0], Funct3 → 32-bit extended result. Shared with any future cache fill path.
- Counter width is $clog2(TIMEOUT_CYCLES+1).

## Test plan
- SW 0xDEADBEEF to 0x100, Ack on first Req cycle → WStrb=1111, Addr=0x100, Stall_M high exactly 2 cycles.
- SB 0x000000A5 to 0x103 → WStrb=1000, WData=0xA5A5A5A5. Then LB from 0x103 with RData=0xA5000000 → ReadData_M=0xFFFFFFA5; LBU gives 0x000000A5.
- LH from 0x102, RData=0x80010000, Ack delayed 3 cycles → ReadData_M=0xFFFF8001, Stall_M high 5 cycles.
- LW from 0x101 → Misaligned_M one pulse, Dmem_Req never asserts, Stall_M=0.
- LW with no Ack, TIMEOUT_CYCLES=4 → Req high 4 cycles, Access_Fault_M pulse, ReadData_M=0, return to IDLE.
- Reset asserted on the second REQ cycle, then Ack one cycle later → Req low after reset edge, state IDLE, ReadData_M stays 0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: memory-type encodings, FSM states and defaults shared by the load/store unit
package mem_access_pkg;
   localparam logic [2:0] MT_B  = 3'b000;
   localparam logic [2:0] MT_H  = 3'b001;
   localparam logic [2:0] MT_W  = 3'b010;
   localparam logic [2:0] MT_BU = 3'b100;
   localparam logic [2:0] MT_HU = 3'b101;
   localparam int DEF_TIMEOUT_CYCLES = 16;
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   function automatic logic mt_legal(input logic [2:0] f3, input logic store);
      return f3 == MT_B || f3 == MT_H || f3 == MT_W || (!store && (f3 == MT_BU || f3 == MT_HU));
   endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/half of a read word and sign- or zero-extends it
module load_extend
   import mem_access_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] ext
);
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      b = rdata[{addr_lo, 3'b000} +: 8];
      h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      ext = funct3 == MT_B  ? {{24{b[7]}}, b} :
            funct3 == MT_BU ? {24'h0, b} :
            funct3 == MT_H  ? {{16{h[15]}}, h} :
            funct3 == MT_HU ? {16'h0, h} : rdata;
   end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: Mem-stage load/store unit running a req/ack data-memory transaction with stall and faults
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MemRead_M,
   input  logic        MemWrite_M,
   input  logic [2:0]  Funct3_M,
   input  logic [31:0] Addr_M,
   input  logic [31:0] WriteData_M,
   output logic        Dmem_Req,
   output logic        Dmem_We,
   output logic [31:0] Dmem_Addr,
   output logic [3:0]  Dmem_WStrb,
   output logic [31:0] Dmem_WData,
   input  logic        Dmem_Ack,
   input  logic [31:0] Dmem_RData,
   output logic [31:0] ReadData_M,
   output logic        Stall_M,
   output logic        Misaligned_M,
   output logic        Access_Fault_M
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   state_t state, state_nxt;
   logic [CW-1:0] cnt;
   logic access, legal, misal, start, ack_hit, timeout, is_load_q, fault_q;
   logic [2:0] f3_q;
   logic [1:0] off_q;
   logic [3:0] strb;
   logic [31:0] wdata, ext;
   load_extend u_ext (.rdata(Dmem_RData), .addr_lo(off_q), .funct3(f3_q), .ext(ext));
   always_comb begin
      access = MemRead_M | MemWrite_M;
      legal = mt_legal(Funct3_M, MemWrite_M);
      misal = Funct3_M[1:0] == 2'b01 ? Addr_M[0] : Funct3_M == MT_W ? |Addr_M[1:0] : 1'b0;
      start = state == IDLE && access && legal && !misal;
      ack_hit = state == REQ && Dmem_Ack;
      timeout = state == REQ && !Dmem_Ack && cnt == CW'(TIMEOUT_CYCLES - 1);
      state_nxt = start ? REQ : (ack_hit || timeout) ? DONE : state == DONE ? IDLE : state;
      strb = !MemWrite_M ? 4'b0000 :
             Funct3_M == MT_B ? 4'b0001 << Addr_M[1:0] :
             Funct3_M == MT_H ? (Addr_M[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wdata = Funct3_M == MT_B ? {4{WriteData_M[7:0]}} :
              Funct3_M == MT_H ? {2{WriteData_M[15:0]}} : WriteData_M;
      Dmem_Req = state == REQ;
      Stall_M = start || state == REQ;
      Misaligned_M = state == IDLE && access && legal && misal;
      Access_Fault_M = (state == IDLE && access && !legal) || (state == DONE && fault_q);
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
         cnt <= '0;
         Dmem_We <= 1'b0;
         Dmem_Addr <= '0;
         Dmem_WStrb <= '0;
         Dmem_WData <= '0;
         ReadData_M <= '0;
         fault_q <= 1'b0;
         is_load_q <= 1'b0;
         f3_q <= '0;
         off_q <= '0;
      end else begin
         state <= state_nxt;
         cnt <= state == REQ ? cnt + 1'b1 : '0;
         fault_q <= timeout;
         if (start) begin
            Dmem_We <= MemWrite_M;
            Dmem_Addr <= {Addr_M[31:2], 2'b00};
            Dmem_WStrb <= strb;
            Dmem_WData <= wdata;
            is_load_q <= MemRead_M;
            f3_q <= Funct3_M;
            off_q <= Addr_M[1:0];
         end
         if (ack_hit && is_load_q)
            ReadData_M <= ext;
         else if (timeout)
            ReadData_M <= '0;
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized load/store transactions checked against a byte-arithmetic reference model
module tb_mem_access_unit;
   import mem_access_pkg::*;
   localparam int T = 4;
   logic Clk = 1'b0;
   logic Reset = 1'b1;
   logic MemRead_M = 1'b0;
   logic MemWrite_M = 1'b0;
   logic [2:0] Funct3_M = '0;
   logic [31:0] Addr_M = '0;
   logic [31:0] WriteData_M = '0;
   logic Dmem_Ack = 1'b0;
   logic [31:0] Dmem_RData = '0;
   logic Dmem_Req, Dmem_We, Stall_M, Misaligned_M, Access_Fault_M;
   logic [31:0] Dmem_Addr, Dmem_WData, ReadData_M;
   logic [3:0] Dmem_WStrb;
   int checks = 0;
   int errors = 0;
   logic [31:0] last_rd = '0;
   mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
      .Clk(Clk), .Reset(Reset), .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
      .Funct3_M(Funct3_M), .Addr_M(Addr_M), .WriteData_M(WriteData_M),
      .Dmem_Req(Dmem_Req), .Dmem_We(Dmem_We), .Dmem_Addr(Dmem_Addr), .Dmem_WStrb(Dmem_WStrb),
      .Dmem_WData(Dmem_WData), .Dmem_Ack(Dmem_Ack), .Dmem_RData(Dmem_RData),
      .ReadData_M(ReadData_M), .Stall_M(Stall_M), .Misaligned_M(Misaligned_M),
      .Access_Fault_M(Access_Fault_M)
   );
   always #5 Clk = ~Clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
      int unsigned off, b, h;
      off = addr % 4;
      b = (rd >> (8 * off)) & 255;
      h = (rd >> (8 * (off & 2))) & 65535;
      if (f3 == MT_B) return b >= 128 ? b + 32'hFFFF_FF00 : b;
      if (f3 == MT_BU) return b;
      if (f3 == MT_H) return h >= 32768 ? h + 32'hFFFF_0000 : h;
      if (f3 == MT_HU) return h;
      return rd;
   endfunction
   task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd, input int delay);
      bit ill, mis, acked;
      int stalls;
      int unsigned off;
      logic [3:0] es;
      logic [31:0] ew;
      off = addr % 4;
      ill = st ? f3 > 2 : (f3 == 3 || f3 >= 6);
      mis = !ill && ((f3 % 4 == 1 && addr % 2 != 0) || (f3 == 2 && off != 0));
      es = !st ? 4'd0 : f3 == MT_B ? 4'(1 << off) : f3 == MT_H ? 4'(3 << off) : 4'd15;
      ew = f3 == MT_B ? (wd & 255) * 32'h0101_0101 : f3 == MT_H ? (wd & 65535) * 32'h0001_0001 : wd;
      @(negedge Clk);
      MemWrite_M = st;
      MemRead_M = !st;
      Funct3_M = f3;
      Addr_M = addr;
      WriteData_M = wd;
      Dmem_Ack = 1'b0;
      #1;
      check("fault_idle", 32'(Access_Fault_M), 32'(ill));
      check("misaligned", 32'(Misaligned_M), 32'(mis));
      check("stall_first", 32'(Stall_M), 32'(!(ill || mis)));
      check("req_idle", 32'(Dmem_Req), 0);
      if (ill || mis) return;
      stalls = 1;
      acked = 1'b0;
      for (int k = 0; k < T; k++) begin
         @(negedge Clk);
         acked = (k == delay);
         Dmem_Ack = acked;
         Dmem_RData = acked ? rd : $urandom;
         #1;
         check("req", 32'(Dmem_Req), 1);
         check("we", 32'(Dmem_We), 32'(st));
         check("addr", Dmem_Addr, addr & ~32'd3);
         check("strb", 32'(Dmem_WStrb), 32'(es));
         if (st) check("wdata", Dmem_WData, ew);
         stalls += int'(Stall_M);
         if (acked) break;
      end
      @(negedge Clk);
      Dmem_Ack = 1'($urandom_range(0, 1));
      Dmem_RData = $urandom;
      #1;
      if (!acked) last_rd = '0;
      else if (!st) last_rd = ref_load(f3, addr, rd);
      check("stall_done", 32'(Stall_M), 0);
      check("req_done", 32'(Dmem_Req), 0);
      check("fault_done", 32'(Access_Fault_M), 32'(!acked));
      check("read_data", ReadData_M, last_rd);
      check("stall_cycles", stalls, acked ? delay + 2 : T + 1);
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge Clk);
         MemRead_M = 1'b0;
         MemWrite_M = 1'b0;
         Dmem_Ack = 1'($urandom_range(0, 1));
         Dmem_RData = $urandom;
         #1;
         check("idle_stall", 32'(Stall_M), 0);
         check("idle_req", 32'(Dmem_Req), 0);
         check("idle_misal", 32'(Misaligned_M), 0);
         check("idle_fault", 32'(Access_Fault_M), 0);
         check("idle_rdata", ReadData_M, last_rd);
      end
   endtask
   initial begin
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      check("rst_req", 32'(Dmem_Req), 0);
      check("rst_we", 32'(Dmem_We), 0);
      check("rst_addr", Dmem_Addr, 0);
      check("rst_strb", 32'(Dmem_WStrb), 0);
      check("rst_wdata", Dmem_WData, 0);
      check("rst_rdata", ReadData_M, 0);
      check("rst_stall", 32'(Stall_M), 0);
      check("rst_misal", 32'(Misaligned_M), 0);
      check("rst_fault", 32'(Access_Fault_M), 0);
      do_access(1, MT_W, 32'h100, 32'hDEAD_BEEF, 0, 0);
      do_access(1, MT_B, 32'h103, 32'h0000_00A5, 0, 0);
      do_access(0, MT_B, 32'h103, 0, 32'hA500_0000, 0);
      do_access(0, MT_BU, 32'h103, 0, 32'hA500_0000, 0);
      do_access(0, MT_H, 32'h102, 0, 32'h8001_0000, 3);
      do_access(0, MT_W, 32'h101, 0, 0, 0);
      idle(2);
      do_access(0, MT_W, 32'h104, 0, 32'h1234_5678, 99);
      idle(1);
      do_access(0, 3'b011, 32'h108, 0, 0, 0);
      do_access(1, MT_BU, 32'h108, 32'h55, 0, 0);
      idle(1);
      @(negedge Clk);
      MemRead_M = 1'b1;
      MemWrite_M = 1'b0;
      Funct3_M = MT_W;
      Addr_M = 32'h200;
      Dmem_Ack = 1'b0;
      @(negedge Clk);
      #1 check("rst_req1", 32'(Dmem_Req), 1);
      @(negedge Clk);
      Reset = 1'b1;
      #1 check("rst_req2", 32'(Dmem_Req), 1);
      @(negedge Clk);
      Reset = 1'b0;
      MemRead_M = 1'b0;
      Dmem_Ack = 1'b1;
      Dmem_RData = 32'hCAFE_F00D;
      last_rd = '0;
      #1;
      check("rst_req_after", 32'(Dmem_Req), 0);
      check("rst_stall_after", 32'(Stall_M), 0);
      idle(2);
      for (int i = 0; i < 80; i++) begin
         do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom, $urandom_range(0, 5));
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
